branch_trace_fifo: RTL and testbench
====================================

Name: branch_trace_fifo

Overview:
- Buffers control-flow target addresses from the core trace port and serves them to ROPDetector's FIFO read interface (iFifo_Data / iFifo_Empty / oFifo_RdEn).
- An optional range filter drops addresses outside the trampoline window before they are stored.
- Reports overflow and dropped-entry statistics to software.

Parameters:
- ADDR_W, 32, trace address width
- DEPTH, 16, entries; power of two, at least 2
- CNT_W, 16, width of the drop counter

Ports:
- iClk  in  1  clock
- iRsn  in  1  reset, synchronous active-low
- iTrace_Valid  in  1  trace address valid this cycle
- iTrace_Addr  in  ADDR_W  branch/jump target address
- iFilter_En  in  1  1 = store only addresses inside the trampoline window
- iTRAMPOLINE_START  in  ADDR_W  window lower bound, inclusive
- iTRAMPOLINE_END  in  ADDR_W  window upper bound, inclusive
- iFifo_RdEn  in  1  pop request; connects to ROPDetector oFifo_RdEn
- oFifo_Data  out  ADDR_W  popped entry, registered; connects to iFifo_Data
- oFifo_Empty  out  1  no stored entries; connects to iFifo_Empty
- oLevel  out  $clog2(DEPTH)+1  current occupancy
- oOverflow  out  1  sticky: at least one push was lost because the FIFO was full
- iClr_Overflow  in  1  clears oOverflow and oDropCnt
- oDropCnt  out  CNT_W  saturating count of pushes lost to full

Behaviour:
- Clock and reset:
  - Single clock iClk.
  - Reset is synchronous, active-low. When iRsn=0 at a rising edge: pointers=0, level=0, oFifo_Empty=1, oFifo_Data=0, oOverflow=0, oDropCnt=0.
  - Reset mid-operation discards all stored entries. No push or pop takes effect in the reset cycle.
- Push qualification:
  - push_req = iTrace_Valid && (!iFilter_En || (iTRAMPOLINE_START <= iTrace_Addr && iTrace_Addr <= iTRAMPOLINE_END)).
  - Comparison is unsigned, full ADDR_W.
  - If START > END with the filter enabled, nothing qualifies.
  - Filtered addresses are not counted as drops.
- Pop:
  - pop = iFifo_RdEn && !oFifo_Empty, evaluated at the edge.
  - On pop, oFifo_Data <= mem[rd_ptr] at that edge, so data is valid the cycle after RdEn (1-cycle read latency).
  - rd_ptr increments on pop.
  - RdEn while empty is ignored: oFifo_Data holds its value and no pointer moves.
- Push: push = push_req && (level < DEPTH || pop). On push, mem[wr_ptr] <= iTrace_Addr and wr_ptr increments.
- Full and simultaneous cases:
  - Full with a simultaneous pop: both operations occur and level is unchanged.
  - Full with no pop: the push is dropped, oOverflow <= 1, and oDropCnt increments, saturating at all-ones.
  - Empty with simultaneous push and RdEn: no bypass. The push is stored, the pop is ignored, and the entry is readable from the next cycle.
- Pointers and level:
  - Pointers are $clog2(DEPTH)+1 bits; the extra MSB distinguishes full from empty.
  - Pointers wrap naturally modulo 2*DEPTH. Index = low bits.
  - Level is a register: +1 on push only, -1 on pop only, unchanged otherwise.
  - oFifo_Empty = (level == 0), driven from the registered level.
- Overflow clear:
  - iClr_Overflow=1 clears oOverflow and oDropCnt at the edge.
  - If a drop occurs in the same cycle, the clear wins for oDropCnt (reads 0) but oOverflow is set to 1, so the event is not lost.
- Ordering: strict FIFO order is preserved across wrap-around.

Decomposition:
- Package rop_pkg holds:
  - ADDR_W default
  - typedef addr_t
  - function in_trampoline(addr, start, end), shared with ROPDetector's range checks
- Sub-module trace_ram: DEPTH x ADDR_W simple dual-port array with one write port and one registered read port. Its read register drives oFifo_Data.
- Pointer, level and statistics logic stays in branch_trace_fifo.

Test Plan:
- Reset then push 0x00001000, 0x80000004, 0x00002000 with the filter off; assert RdEn on consecutive cycles -> oFifo_Data reads 0x00001000, 0x80000004, 0x00002000 one cycle after each RdEn; oFifo_Empty=1 after the third pop; level 3 -> 0.
- Filter on, START=0x80000000, END=0x80000024; push 0x7FFFFFFF, 0x80000000, 0x80000024, 0x80000025 -> only 0x80000000 and 0x80000024 stored; oLevel=2; oDropCnt=0.
- DEPTH=16: push 18 entries with no reads -> oLevel=16, oOverflow=1, oDropCnt=2; drain all -> the first 16 values in order; iClr_Overflow -> oOverflow=0, oDropCnt=0.
- Full FIFO with push and RdEn in the same cycle -> oLevel stays 16, no drop, popped value = oldest entry.
- Empty FIFO with push 0x80000008 and RdEn in the same cycle -> oFifo_Data unchanged, oLevel=1; RdEn next cycle -> 0x80000008.
- Wrap and reset: 40 randomized push/pop cycles crossing the wrap boundary -> order matches a scoreboard. Then drive iRsn=0 for one edge with 5 entries stored -> oLevel=0, oFifo_Empty=1, oFifo_Data=0.

Source files
------------

// File: rtl/rop_pkg.sv
// Types and helpers shared by the branch trace FIFO and ROPDetector's range checks.
package rop_pkg;

  localparam int ADDR_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;

  // Inclusive unsigned window test; an inverted window (start > end) matches nothing.
  function automatic logic in_trampoline(input addr_t addr, input addr_t start_a, input addr_t end_a);
    return (start_a <= addr) && (addr <= end_a);
  endfunction

endpackage

// File: rtl/branch_trace_fifo_if.sv
// Trace push side and FIFO read side of the branch trace buffer.
// Handshake: a trace address is offered whenever iTrace_Valid=1 and is never back-pressured
// (it is stored, filtered or counted as dropped); iFifo_RdEn pops only when oFifo_Empty=0,
// and the popped entry appears on oFifo_Data one cycle later.
interface branch_trace_fifo_if #(
  parameter int ADDR_W = 32
);
  logic              iTrace_Valid;
  logic [ADDR_W-1:0] iTrace_Addr;
  logic              iFifo_RdEn;
  logic [ADDR_W-1:0] oFifo_Data;
  logic              oFifo_Empty;

  modport master (
    output iTrace_Valid, iTrace_Addr, iFifo_RdEn,
    input  oFifo_Data, oFifo_Empty
  );

  modport slave (
    input  iTrace_Valid, iTrace_Addr, iFifo_RdEn,
    output oFifo_Data, oFifo_Empty
  );
endinterface

// File: rtl/trace_ram.sv
// DEPTH x ADDR_W storage: one write port, one registered read port that clears on reset.
module trace_ram #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [ADDR_W-1:0]        wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [ADDR_W-1:0]        rdata_o
);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // A same-address write and read in one cycle returns the old entry (oldest when full).
  always_ff @(posedge clk_i) begin
    if (!rst_ni)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/branch_trace_fifo.sv
// Branch target trace buffer with optional trampoline-window filter and overflow statistics.
module branch_trace_fifo #(
  parameter int ADDR_W = rop_pkg::ADDR_W,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                     iClk,
  input  logic                     iRsn,
  branch_trace_fifo_if.slave       bus,
  input  logic                     iFilter_En,
  input  logic [ADDR_W-1:0]        iTRAMPOLINE_START,
  input  logic [ADDR_W-1:0]        iTRAMPOLINE_END,
  output logic [$clog2(DEPTH):0]   oLevel,
  output logic                     oOverflow,
  input  logic                     iClr_Overflow,
  output logic [CNT_W-1:0]         oDropCnt
);
  import rop_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);

  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d, lvl_q, lvl_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             push_req, pop, push, drop, full;

  assign full     = (lvl_q == FULL_LVL);
  assign push_req = bus.iTrace_Valid &&
                    (!iFilter_En || in_trampoline(bus.iTrace_Addr, iTRAMPOLINE_START, iTRAMPOLINE_END));
  assign pop      = bus.iFifo_RdEn && (lvl_q != '0);
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    lvl_d  = lvl_q;
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (push) wr_d = wr_q + PW'(1);
    if (pop)  rd_d = rd_q + PW'(1);
    if (push && !pop)      lvl_d = lvl_q + PW'(1);
    else if (pop && !push) lvl_d = lvl_q - PW'(1);
    if (iClr_Overflow) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end else if (drop && (drop_q != '1)) begin
      drop_d = drop_q + CNT_W'(1);
    end
    // A drop coinciding with a clear still leaves the sticky flag set.
    if (drop) ovf_d = 1'b1;
  end

  always_ff @(posedge iClk) begin
    if (!iRsn) begin
      wr_q   <= '0;
      rd_q   <= '0;
      lvl_q  <= '0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      lvl_q  <= lvl_d;
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
    end
  end

  trace_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (iClk),
    .rst_ni  (iRsn),
    .we_i    (push && iRsn),
    .waddr_i (wr_q[AW-1:0]),
    .wdata_i (bus.iTrace_Addr),
    .re_i    (pop),
    .raddr_i (rd_q[AW-1:0]),
    .rdata_o (bus.oFifo_Data)
  );

  assign bus.oFifo_Empty = (lvl_q == '0);
  assign oLevel          = lvl_q;
  assign oOverflow       = ovf_q;
  assign oDropCnt        = drop_q;

endmodule

// File: tb/tb_branch_trace_fifo.sv
// Self-checking bench for branch_trace_fifo: vector table, directed corner cases, scoreboard.
module tb_branch_trace_fifo;
  import rop_pkg::*;

  localparam int DEPTH = 16;
  localparam int CNT_W = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rsn;
  logic             filt;
  addr_t            st, en;
  logic             clr;
  logic [LW-1:0]    level;
  logic             ovf;
  logic [CNT_W-1:0] dcnt;

  always #5 clk = ~clk;

  branch_trace_fifo_if #(.ADDR_W(32)) bus();

  branch_trace_fifo #(
    .ADDR_W (32),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .iClk              (clk),
    .iRsn              (rsn),
    .bus               (bus),
    .iFilter_En        (filt),
    .iTRAMPOLINE_START (st),
    .iTRAMPOLINE_END   (en),
    .oLevel            (level),
    .oOverflow         (ovf),
    .iClr_Overflow     (clr),
    .oDropCnt          (dcnt)
  );

  // Scoreboard: accepted pushes queue here, pops compare against the front.
  logic [31:0]      exp_q[$];
  logic [31:0]      m_data;
  logic             m_ovf;
  logic [CNT_W-1:0] m_drop;
  int               n_vec = 0;
  int               n_err = 0;

  typedef struct {
    logic        v;
    logic [31:0] a;
    logic        f;
    logic        rd;
    int          lvl;
    logic [31:0] data;
    logic        empty;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [31:0] a, input logic rd, input logic c);
    logic preq, pop, full, drop_ev;
    rsn = r; bus.iTrace_Valid = v; bus.iTrace_Addr = a; bus.iFifo_RdEn = rd; clr = c;
    @(posedge clk);
    if (!r) begin
      exp_q.delete();
      m_data = '0; m_ovf = 1'b0; m_drop = '0;
    end else begin
      preq    = v && (!filt || (st <= a && a <= en));
      full    = (exp_q.size() == DEPTH);
      pop     = rd && (exp_q.size() != 0);
      drop_ev = preq && full && !pop;
      if (pop) m_data = exp_q.pop_front();
      if (preq && !drop_ev) exp_q.push_back(a);
      if (c) m_drop = '0;
      else if (drop_ev && m_drop != {CNT_W{1'b1}}) m_drop = m_drop + 1'b1;
      if (c) m_ovf = 1'b0;
      if (drop_ev) m_ovf = 1'b1;
    end
    #1;
    chk("data",  bus.oFifo_Data, m_data);
    chk("level", 32'(level), 32'(exp_q.size()));
    chk("empty", 32'(bus.oFifo_Empty), 32'(exp_q.size() == 0));
    chk("ovf",   32'(ovf), 32'(m_ovf));
    chk("drop",  32'(dcnt), 32'(m_drop));
  endtask

  initial begin
    logic [31:0] prev;
    rsn = 1'b0; filt = 1'b0; st = '0; en = '0; clr = 1'b0;
    bus.iTrace_Valid = 1'b0; bus.iTrace_Addr = '0; bus.iFifo_RdEn = 1'b0;
    m_data = '0; m_ovf = 1'b0; m_drop = '0;

    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h55, 1'b1, 1'b0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_empty", 32'(bus.oFifo_Empty), 32'd1);

    // Ordered push/pop with filter off, then window filtering.
    tbl[0] = '{1'b1, 32'h0000_1000, 1'b0, 1'b0, 1, 32'h0,         1'b0};
    tbl[1] = '{1'b1, 32'h8000_0004, 1'b0, 1'b0, 2, 32'h0,         1'b0};
    tbl[2] = '{1'b1, 32'h0000_2000, 1'b0, 1'b0, 3, 32'h0,         1'b0};
    tbl[3] = '{1'b0, 32'h0,         1'b0, 1'b1, 2, 32'h0000_1000, 1'b0};
    tbl[4] = '{1'b0, 32'h0,         1'b0, 1'b1, 1, 32'h8000_0004, 1'b0};
    tbl[5] = '{1'b0, 32'h0,         1'b0, 1'b1, 0, 32'h0000_2000, 1'b1};
    tbl[6] = '{1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, 0, 32'h0000_2000, 1'b1};
    tbl[7] = '{1'b1, 32'h8000_0000, 1'b1, 1'b0, 1, 32'h0000_2000, 1'b0};
    tbl[8] = '{1'b1, 32'h8000_0024, 1'b1, 1'b0, 2, 32'h0000_2000, 1'b0};
    tbl[9] = '{1'b1, 32'h8000_0025, 1'b1, 1'b0, 2, 32'h0000_2000, 1'b0};
    st = 32'h8000_0000; en = 32'h8000_0024;
    for (int i = 0; i < 10; i++) begin
      filt = tbl[i].f;
      step(1'b1, tbl[i].v, tbl[i].a, tbl[i].rd, 1'b0);
      chk("tbl_level", 32'(level), 32'(tbl[i].lvl));
      chk("tbl_data",  bus.oFifo_Data, tbl[i].data);
      chk("tbl_empty", 32'(bus.oFifo_Empty), 32'(tbl[i].empty));
    end
    chk("filt_drop", 32'(dcnt), 32'd0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("filt_pop2", bus.oFifo_Data, 32'h8000_0024);
    filt = 1'b0;

    // Overflow: 18 pushes into 16 entries, drain in order, then clear.
    for (int i = 0; i < 18; i++) step(1'b1, 1'b1, 32'h100 + 32'(i) * 4, 1'b0, 1'b0);
    chk("ovf_level", 32'(level), 32'd16);
    chk("ovf_flag",  32'(ovf), 32'd1);
    chk("ovf_cnt",   32'(dcnt), 32'd2);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      chk("drain", bus.oFifo_Data, 32'h100 + 32'(i) * 4);
    end
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("clr_flag", 32'(ovf), 32'd0);
    chk("clr_cnt",  32'(dcnt), 32'd0);

    // Full with simultaneous push and pop; clear racing a drop; counter saturation.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h300, 1'b1, 1'b0);
    chk("fullpp_level", 32'(level), 32'd16);
    chk("fullpp_data",  bus.oFifo_Data, 32'h200);
    chk("fullpp_drop",  32'(dcnt), 32'd0);
    step(1'b1, 1'b1, 32'h301, 1'b0, 1'b1);
    chk("clrdrop_flag", 32'(ovf), 32'd1);
    chk("clrdrop_cnt",  32'(dcnt), 32'd0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 32'h400 + 32'(i), 1'b0, 1'b0);
    chk("sat_cnt", 32'(dcnt), 32'hF);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);

    // Empty with push and RdEn together: no bypass.
    prev = bus.oFifo_Data;
    step(1'b1, 1'b1, 32'h8000_0008, 1'b1, 1'b0);
    chk("nobyp_data",  bus.oFifo_Data, prev);
    chk("nobyp_level", 32'(level), 32'd1);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("nobyp_pop", bus.oFifo_Data, 32'h8000_0008);

    // Randomised traffic across the pointer wrap.
    for (int i = 0; i < 40; i++)
      step(1'b1, 1'($urandom_range(0, 9) < 7), $urandom, 1'($urandom_range(0, 1)), 1'b0);

    // Reset with five entries held.
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 32'h500 + 32'(i), 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("pre_rst_data", bus.oFifo_Data, 32'h500);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_empty", 32'(bus.oFifo_Empty), 32'd1);
    chk("mid_rst_data",  bus.oFifo_Data, 32'd0);
    step(1'b1, 1'b1, 32'hABC, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("post_rst_pop", bus.oFifo_Data, 32'hABC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
